// File: rtl/ctrl_regfile.sv
// Dual-read, single-write register file holding the FIR sample delay line and MAC scratch words.
// Reads are registered; a same-cycle write is visible to the read (write-to-read bypass).
module ctrl_regfile #(
   parameter int unsigned AW = 3,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic          new_smp_i,
   input  logic [AW-1:0] ard_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] ar1_i,
   input  logic [AW-1:0] ar2_i,
   output logic [DW-1:0] rd1_o,
   output logic [DW-1:0] rd2_o,
   output logic          rvalid_o,
   output logic          rd1_init_o,
   output logic          rd2_init_o,
   output logic [AW:0]   smp_cnt_o
);

   localparam int unsigned Depth = 2 ** AW;
   localparam logic [AW:0] CntMax = Depth[AW:0];
   localparam logic [AW:0] CntOne = {{AW{1'b0}}, 1'b1};

   logic [Depth-1:0][DW-1:0] mem_q, mem_d;
   logic [Depth-1:0]         wf_q, wf_d;
   logic [AW:0]              smp_cnt_q, smp_cnt_d;
   logic [DW-1:0]            rd1_q, rd2_q;
   logic                     rvalid_q, rd1_init_q, rd2_init_q;

   // Post-write view of storage; reads index this so the bypass comes for free.
   always_comb begin
      mem_d     = mem_q;
      wf_d      = wf_q;
      smp_cnt_d = smp_cnt_q;
      if (we_i && new_smp_i) begin
         mem_d = {mem_q[Depth-2:0], wdata_i};
         wf_d  = {wf_q[Depth-2:0], 1'b1};
         if (smp_cnt_q != CntMax) begin
            smp_cnt_d = smp_cnt_q + CntOne;
         end
      end else if (we_i) begin
         mem_d[ard_i] = wdata_i;
         wf_d[ard_i]  = 1'b1;
      end
   end

   // Storage words are deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_q <= mem_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wf_q       <= '0;
         smp_cnt_q  <= '0;
         rvalid_q   <= 1'b0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         rd1_init_q <= 1'b0;
         rd2_init_q <= 1'b0;
      end else begin
         wf_q      <= wf_d;
         smp_cnt_q <= smp_cnt_d;
         rvalid_q  <= re_i;
         if (re_i) begin
            rd1_q      <= mem_d[ar1_i];
            rd2_q      <= mem_d[ar2_i];
            rd1_init_q <= wf_d[ar1_i];
            rd2_init_q <= wf_d[ar2_i];
         end
      end
   end

   assign rd1_o      = rd1_q;
   assign rd2_o      = rd2_q;
   assign rvalid_o   = rvalid_q;
   assign rd1_init_o = rd1_init_q;
   assign rd2_init_o = rd2_init_q;
   assign smp_cnt_o  = smp_cnt_q;

endmodule

// File: tb/tb_ctrl_regfile.sv
// Self-checking bench for ctrl_regfile: behavioural model feeds a scoreboard of expected read results.
module tb_ctrl_regfile;

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 16;
   localparam int unsigned Depth = 8;

   logic          clk = 1'b0;
   logic          rst, we_i, new_smp_i, re_i;
   logic [AW-1:0] ard_i, ar1_i, ar2_i;
   logic [DW-1:0] wdata_i;
   logic [DW-1:0] rd1_o, rd2_o;
   logic          rvalid_o, rd1_init_o, rd2_init_o;
   logic [AW:0]   smp_cnt_o;

   always #5 clk = ~clk;

   ctrl_regfile #(.AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .we_i       (we_i),
      .new_smp_i  (new_smp_i),
      .ard_i      (ard_i),
      .wdata_i    (wdata_i),
      .re_i       (re_i),
      .ar1_i      (ar1_i),
      .ar2_i      (ar2_i),
      .rd1_o      (rd1_o),
      .rd2_o      (rd2_o),
      .rvalid_o   (rvalid_o),
      .rd1_init_o (rd1_init_o),
      .rd2_init_o (rd2_init_o),
      .smp_cnt_o  (smp_cnt_o)
   );

   typedef struct {
      logic          r, w, ns;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          rr;
      logic [AW-1:0] a1, a2;
   } stim_t;

   typedef struct {
      logic          vld, i1, i2;
      logic [AW:0]   cnt;
      logic [DW-1:0] d1, d2;
      logic          k1, k2;  // data value is known to the model
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   logic [DW-1:0]    m_mem [Depth];
   logic [Depth-1:0] m_wf = '0;
   logic [Depth-1:0] m_k = '0;
   logic [AW:0]      m_cnt = '0;
   exp_t             m_out;

   function automatic stim_t mk(input logic r, w, ns, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic rr,
                                input logic [AW-1:0] a1, a2);
      stim_t s;
      s.r = r; s.w = w; s.ns = ns; s.a = a; s.d = d; s.rr = rr; s.a1 = a1; s.a2 = a2;
      return s;
   endfunction

   // Applies one cycle of stimulus, advances the model and queues what the DUT must show after it.
   task automatic drive(input stim_t s);
      logic [DW-1:0]    nm [Depth];
      logic [Depth-1:0] nwf, nk;
      rst = s.r; we_i = s.w; new_smp_i = s.ns; ard_i = s.a; wdata_i = s.d;
      re_i = s.rr; ar1_i = s.a1; ar2_i = s.a2;
      nm = m_mem; nwf = m_wf; nk = m_k;
      if (s.r) begin
         m_wf = '0;
         m_cnt = '0;
         m_out.vld = 1'b0; m_out.i1 = 1'b0; m_out.i2 = 1'b0; m_out.cnt = '0;
         m_out.d1 = '0; m_out.d2 = '0; m_out.k1 = 1'b1; m_out.k2 = 1'b1;
      end else begin
         if (s.w && s.ns) begin
            for (int i = 7; i > 0; i--) begin
               nm[i] = m_mem[i-1]; nk[i] = m_k[i-1]; nwf[i] = m_wf[i-1];
            end
            nm[0] = s.d; nk[0] = 1'b1; nwf[0] = 1'b1;
            if (m_cnt != 4'd8) m_cnt = m_cnt + 4'd1;
         end else if (s.w) begin
            nm[s.a] = s.d; nk[s.a] = 1'b1; nwf[s.a] = 1'b1;
         end
         m_out.vld = s.rr;
         if (s.rr) begin
            m_out.d1 = nm[s.a1]; m_out.k1 = nk[s.a1]; m_out.i1 = nwf[s.a1];
            m_out.d2 = nm[s.a2]; m_out.k2 = nk[s.a2]; m_out.i2 = nwf[s.a2];
         end
         m_out.cnt = m_cnt;
         m_mem = nm; m_wf = nwf; m_k = nk;
      end
      sb.push_back(m_out);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t st[$];
      exp_t  e;
      st.push_back(mk(1, 0, 0, 0, 16'h0, 0, 0, 0));
      st.push_back(mk(0, 0, 0, 0, 16'h0, 1, 3, 5));
      st.push_back(mk(0, 0, 0, 0, 16'h0, 0, 0, 0));
      foreach (st[i]) begin
         drive(st[i]);
         e = sb.pop_front();
         checks++;
         if ({rvalid_o, rd1_init_o, rd2_init_o, smp_cnt_o} !== {e.vld, e.i1, e.i2, e.cnt}) begin
            failures++;
            $display("FAIL reset_ctl[%0d]: got v/i1/i2/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", i,
                     rvalid_o, rd1_init_o, rd2_init_o, smp_cnt_o, e.vld, e.i1, e.i2, e.cnt);
         end
         if (e.k1 && e.k2) begin
            checks++;
            if ({rd1_o, rd2_o} !== {e.d1, e.d2}) begin
               failures++;
               $display("FAIL reset_data[%0d]: got %h/%h want %h/%h", i, rd1_o, rd2_o, e.d1, e.d2);
            end
         end
      end
   endtask

   task automatic test_write_read();
      stim_t st[$];
      exp_t  e;
      st.push_back(mk(0, 1, 0, 6, 16'h1234, 0, 0, 0));
      st.push_back(mk(0, 0, 0, 0, 16'h0, 1, 6, 6));
      st.push_back(mk(0, 1, 0, 4, 16'h5555, 0, 0, 0));
      st.push_back(mk(0, 0, 0, 0, 16'h0, 0, 1, 1));
      st.push_back(mk(0, 1, 0, 2, 16'hBEEF, 1, 2, 4));
      st.push_back(mk(0, 0, 0, 0, 16'h0, 1, 4, 2));
      foreach (st[i]) begin
         drive(st[i]);
         e = sb.pop_front();
         checks++;
         if ({rvalid_o, rd1_init_o, rd2_init_o, smp_cnt_o} !== {e.vld, e.i1, e.i2, e.cnt}) begin
            failures++;
            $display("FAIL wr_rd_ctl[%0d]: got v/i1/i2/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", i,
                     rvalid_o, rd1_init_o, rd2_init_o, smp_cnt_o, e.vld, e.i1, e.i2, e.cnt);
         end
         if (e.k1 && e.k2) begin
            checks++;
            if ({rd1_o, rd2_o} !== {e.d1, e.d2}) begin
               failures++;
               $display("FAIL wr_rd_data[%0d]: got %h/%h want %h/%h", i, rd1_o, rd2_o, e.d1, e.d2);
            end
         end
      end
   endtask

   task automatic test_shift();
      stim_t st[$];
      exp_t  e;
      for (int n = 1; n <= 9; n++) st.push_back(mk(0, 1, 1, 5, DW'(n), 0, 0, 0));
      st.push_back(mk(0, 0, 0, 0, 16'h0, 1, 0, 7));
      st.push_back(mk(0, 1, 0, 0, 16'h00AA, 0, 0, 0));
      st.push_back(mk(0, 1, 1, 3, 16'h00BB, 1, 0, 1));
      st.push_back(mk(0, 0, 0, 0, 16'h0, 1, 7, 2));
      foreach (st[i]) begin
         drive(st[i]);
         e = sb.pop_front();
         checks++;
         if ({rvalid_o, rd1_init_o, rd2_init_o, smp_cnt_o} !== {e.vld, e.i1, e.i2, e.cnt}) begin
            failures++;
            $display("FAIL shift_ctl[%0d]: got v/i1/i2/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", i,
                     rvalid_o, rd1_init_o, rd2_init_o, smp_cnt_o, e.vld, e.i1, e.i2, e.cnt);
         end
         if (e.k1 && e.k2) begin
            checks++;
            if ({rd1_o, rd2_o} !== {e.d1, e.d2}) begin
               failures++;
               $display("FAIL shift_data[%0d]: got %h/%h want %h/%h", i, rd1_o, rd2_o, e.d1, e.d2);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t st[$];
      exp_t  e;
      st.push_back(mk(0, 1, 0, 1, 16'h1111, 0, 0, 0));
      st.push_back(mk(0, 1, 1, 0, 16'h2222, 1, 1, 0));
      st.push_back(mk(1, 1, 0, 3, 16'h3333, 1, 3, 1));
      st.push_back(mk(0, 0, 0, 0, 16'h0, 1, 3, 1));
      st.push_back(mk(0, 0, 0, 0, 16'h0, 0, 0, 0));
      foreach (st[i]) begin
         drive(st[i]);
         e = sb.pop_front();
         checks++;
         if ({rvalid_o, rd1_init_o, rd2_init_o, smp_cnt_o} !== {e.vld, e.i1, e.i2, e.cnt}) begin
            failures++;
            $display("FAIL rst_mid_ctl[%0d]: got v/i1/i2/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", i,
                     rvalid_o, rd1_init_o, rd2_init_o, smp_cnt_o, e.vld, e.i1, e.i2, e.cnt);
         end
         if (e.k1 && e.k2) begin
            checks++;
            if ({rd1_o, rd2_o} !== {e.d1, e.d2}) begin
               failures++;
               $display("FAIL rst_mid_data[%0d]: got %h/%h want %h/%h", i, rd1_o, rd2_o, e.d1, e.d2);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t st[$];
      exp_t  e;
      for (int n = 0; n < 300; n++) begin
         st.push_back(mk($urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1,
                         $urandom_range(0, 2) == 0, AW'($urandom), DW'($urandom),
                         $urandom_range(0, 3) != 0, AW'($urandom), AW'($urandom)));
      end
      foreach (st[i]) begin
         drive(st[i]);
         e = sb.pop_front();
         checks++;
         if ({rvalid_o, rd1_init_o, rd2_init_o, smp_cnt_o} !== {e.vld, e.i1, e.i2, e.cnt}) begin
            failures++;
            $display("FAIL b2b_ctl[%0d]: got v/i1/i2/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d", i,
                     rvalid_o, rd1_init_o, rd2_init_o, smp_cnt_o, e.vld, e.i1, e.i2, e.cnt);
         end
         if (e.k1) begin
            checks++;
            if (rd1_o !== e.d1) begin
               failures++;
               $display("FAIL b2b_rd1[%0d]: got %h want %h", i, rd1_o, e.d1);
            end
         end
         if (e.k2) begin
            checks++;
            if (rd2_o !== e.d2) begin
               failures++;
               $display("FAIL b2b_rd2[%0d]: got %h want %h", i, rd2_o, e.d2);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_shift();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
